// File: rtl/bit_entry_pkg.sv
// Shared types and default parameters for the serial bit-entry front end.
package bit_entry_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HIST_W          = 4;
    localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, cleared by reset.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/serial_bit_entry.sv
// Debounced step button plus bit switch producing a registered serial bit stream
// with strobe, bit history and accepted-bit count.
module serial_bit_entry
    import bit_entry_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HIST_W          = DEF_HIST_W,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_raw,
    input  logic              sw_raw,
    output logic              bit_out,
    output logic              bit_strobe,
    output logic [HIST_W-1:0] history,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned   DBW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DBW-1:0] CNT_LAST = DBW'(DEBOUNCE_CYCLES - 1);

    logic btn_s;
    logic sw_s;

    sync2 u_sync_btn (.clk(clk), .reset(reset), .d_i(btn_raw), .q_o(btn_s));
    sync2 u_sync_sw  (.clk(clk), .reset(reset), .d_i(sw_raw),  .q_o(sw_s));

    state_e            state_q, state_d;
    logic [DBW-1:0]    cnt_q, cnt_d;
    logic [1:0]        prime_q;
    logic              armed_q;
    logic              accept;
    logic              bit_q;
    logic              strobe_q;
    logic [HIST_W-1:0] hist_q;
    logic [CNT_W-1:0]  count_q;

    // The synchronizer clears to 0 on reset, so a button still held through reset
    // would look like a fresh press. Only arm the FSM once btn_s, after the sync
    // pipeline has refilled with real samples, has been seen low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prime_q <= '0;
            armed_q <= 1'b0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
            armed_q <= armed_q | (prime_q[1] & ~btn_s);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (armed_q && btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 1'b0;
            strobe_q <= 1'b0;
            hist_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            strobe_q <= accept;
            if (accept) begin
                bit_q   <= sw_s;
                hist_q  <= {hist_q[HIST_W-2:0], sw_s};
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign bit_out    = bit_q;
    assign bit_strobe = strobe_q;
    assign history    = hist_q;
    assign bit_count  = count_q;

endmodule

// File: tb/tb_serial_bit_entry.sv
// Directed bench for serial_bit_entry with DEBOUNCE_CYCLES=4, HIST_W=4, CNT_W=8.
module tb_serial_bit_entry;

    localparam int unsigned DC = 4;
    localparam int unsigned HW = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_raw;
    logic          sw_raw;
    logic          bit_out;
    logic          bit_strobe;
    logic [HW-1:0] history;
    logic [CW-1:0] bit_count;

    int unsigned n_vec    = 0;
    int unsigned n_bad    = 0;
    int unsigned n_strobe = 0;
    int unsigned s0;
    logic [3:0]    det;

    serial_bit_entry #(
        .DEBOUNCE_CYCLES(DC),
        .HIST_W(HW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .sw_raw(sw_raw),
        .bit_out(bit_out),
        .bit_strobe(bit_strobe),
        .history(history),
        .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (bit_strobe === 1'b1) n_strobe++;
    endtask

    task automatic steps(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic b);
        int unsigned p0;
        sw_raw  = b;
        btn_raw = 1'b1;
        p0 = n_strobe;
        steps(10);
        chk("press_strobes", n_strobe - p0, 1);
        chk("press_bit", 32'(bit_out), 32'(b));
        btn_raw = 1'b0;
        steps(10);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 1'b0;
        sw_raw  = 1'b0;
        det     = '0;
        steps(2);
        chk("rst_strobe", 32'(bit_strobe), 0);
        chk("rst_count", 32'(bit_count), 0);
        reset = 1'b0;

        // Idle after reset
        s0 = n_strobe;
        steps(20);
        chk("idle_strobes", n_strobe - s0, 0);
        chk("idle_bit", 32'(bit_out), 0);
        chk("idle_hist", 32'(history), 0);
        chk("idle_count", 32'(bit_count), 0);

        // Clean press: strobe only in the cycle after edge E+6
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk($sformatf("lat_strobe_e%0d", i), 32'(bit_strobe), (i == 6) ? 1 : 0);
        end
        chk("lat_bit", 32'(bit_out), 1);
        chk("lat_hist", 32'(history), 4'b0001);
        chk("lat_count", 32'(bit_count), 1);
        s0 = n_strobe;
        steps(15);
        chk("hold_no_repeat", n_strobe - s0, 0);
        btn_raw = 1'b0;
        steps(10);

        // Press bounce 1-0-1-0 then stable
        sw_raw = 1'b0;
        s0 = n_strobe;
        btn_raw = 1'b1; steps(2);
        btn_raw = 1'b0; steps(2);
        btn_raw = 1'b1; steps(2);
        btn_raw = 1'b0; steps(2);
        steps(1);
        chk("bounce_no_strobe", n_strobe - s0, 0);
        btn_raw = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            chk($sformatf("bounce_strobe_e%0d", i), 32'(bit_strobe), (i == 6) ? 1 : 0);
        end
        chk("bounce_bit", 32'(bit_out), 0);
        chk("bounce_hist", 32'(history), 4'b0010);
        chk("bounce_count", 32'(bit_count), 2);
        btn_raw = 1'b0;
        steps(10);

        // Bits 1,1,0,0 as seen by a downstream shift-in detector
        press(1'b1); det = {det[2:0], bit_out};
        press(1'b1); det = {det[2:0], bit_out};
        press(1'b0); det = {det[2:0], bit_out};
        press(1'b0); det = {det[2:0], bit_out};
        chk("seq_detector", 32'(det), 4'b1100);
        chk("seq_hist", 32'(history), 4'b1100);
        chk("seq_count", 32'(bit_count), 6);
        chk("seq_bit", 32'(bit_out), 0);

        // Release bounces with single-cycle glitches, switch moved after acceptance
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        s0 = n_strobe;
        steps(10);
        sw_raw  = 1'b0;
        btn_raw = 1'b0; steps(3);
        btn_raw = 1'b1; steps(1);
        btn_raw = 1'b0; steps(3);
        btn_raw = 1'b1; steps(1);
        btn_raw = 1'b0; steps(10);
        chk("relb_strobes", n_strobe - s0, 1);
        chk("relb_bit", 32'(bit_out), 1);
        chk("relb_hist", 32'(history), 4'b1001);
        chk("relb_count", 32'(bit_count), 7);

        // Reset mid-debounce (PRESS_WAIT, cnt=2) with the button still held
        sw_raw  = 1'b1;
        btn_raw = 1'b1;
        steps(5);
        chk("pre_rst_strobe", 32'(bit_strobe), 0);
        reset = 1'b1;
        #1;
        chk("async_rst_bit", 32'(bit_out), 0);
        chk("async_rst_hist", 32'(history), 0);
        chk("async_rst_count", 32'(bit_count), 0);
        chk("async_rst_strobe", 32'(bit_strobe), 0);
        steps(2);
        reset = 1'b0;
        s0 = n_strobe;
        steps(15);
        chk("held_thru_rst_strobes", n_strobe - s0, 0);
        chk("held_thru_rst_count", 32'(bit_count), 0);
        btn_raw = 1'b0;
        steps(10);
        press(1'b1);
        chk("rearm_count", 32'(bit_count), 1);

        // Counter wrap at 256 accepted bits
        for (int k = 0; k < 254; k++) press(1'b0);
        chk("wrap_pre_count", 32'(bit_count), 255);
        press(1'b0);
        chk("wrap_count", 32'(bit_count), 0);
        chk("wrap_hist", 32'(history), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_bit_entry.md
# serial_bit_entry

Upstream stage of the lab's sequence-detector datapath. It turns two raw board inputs into a clean serial bit stream: a push button (`btn_raw`) that advances one bit per press, and a slide switch (`sw_raw`) that supplies the bit value. It synchronizes both inputs, debounces the button with a four-state FSM, and emits one-cycle strobes with a registered bit. The output drives the detector's serial input and clock enable, plus LED history and count displays.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required to accept a press or release (10 ms at 100 MHz). Minimum 2.
- `HIST_W`, default 4: width of the bit-history shift register.
- `CNT_W`, default 8: width of the accepted-bit counter.

- `clk`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  1  unsynchronized, bouncy step button; 1 = pressed.
- `sw_raw`  in  1  unsynchronized bit-value switch.
- `bit_out`  out  1  last accepted bit, registered, held between strobes.
- `bit_strobe`  out  1  one-cycle pulse; `bit_out` is valid and new in this cycle.
- `history`  out  `HIST_W`  last `HIST_W` accepted bits, newest in bit 0.
- `bit_count`  out  `CNT_W`  number of accepted bits, modulo 2^`CNT_W`.

## Operation
- Each of `btn_raw` and `sw_raw` passes through a 2-flop synchronizer; the synchronized signals are `btn_s` and `sw_s`.
- Debounce FSM on `btn_s`, with a shared counter `cnt` sized `$clog2(DEBOUNCE_CYCLES)`:
  - IDLE: if `btn_s`=1, go to PRESS_WAIT and set `cnt`=0.
  - PRESS_WAIT: if `btn_s`=0, go to IDLE (bounce rejected). Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, go to HELD and accept the bit. Otherwise increment `cnt`.
  - HELD: if `btn_s`=0, go to RELEASE_WAIT and set `cnt`=0. Holding the button never produces a repeat.
  - RELEASE_WAIT: if `btn_s`=1, go to HELD (bounce, no new strobe). Otherwise, if `cnt`==`DEBOUNCE_CYCLES`-1, go to IDLE. Otherwise increment `cnt`.
- Accepting a bit (the PRESS_WAIT→HELD transition) does all of the following on the same edge:
  - `bit_out` <= `sw_s`
  - `history` <= {`history`[HIST_W-2:0], `sw_s`}
  - `bit_count` <= `bit_count`+1, wrapping from 2^`CNT_W`-1 to 0
  - `bit_strobe` <= 1
- `bit_strobe` is 0 in every other cycle.
- `sw_s` is sampled only at acceptance. Switch changes at any other time have no effect.

## Timing
- Reset (asynchronous, any time, including mid-debounce): state=IDLE, `cnt`=0, both synchronizers cleared, `bit_out`=0, `bit_strobe`=0, `history`=0, `bit_count`=0. A press in progress at reset is discarded; the button must be seen low→high again after reset is released.
- Press latency: let edge E be the first clock edge that samples `btn_raw`=1, with the button held stable from then on.
  - `btn_s` goes high after edge E+1.
  - The FSM enters PRESS_WAIT at edge E+2.
  - `bit_strobe` is high in the cycle following edge E+2+`DEBOUNCE_CYCLES`.
- Release must remain stable for `DEBOUNCE_CYCLES` cycles before the next press can be accepted. Minimum spacing between two strobes is 2·`DEBOUNCE_CYCLES`+2 cycles.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles in PRESS_WAIT produces no strobe and no change to any output.
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Shared package `bit_entry_pkg`:
  - state enum with 2-bit encoding: IDLE=0, PRESS_WAIT=1, HELD=2, RELEASE_WAIT=3
  - default parameter constants
- Sub-module `sync2` (2-flop synchronizer, async reset to 0), instantiated twice.
- The FSM, counter, and output registers live in `serial_bit_entry`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HIST_W`=4, `CNT_W`=8.
- Reset then idle for 20 cycles → all outputs 0, `bit_strobe` never asserted.
- `sw_raw`=1, `btn_raw` held high from edge 10 → `bit_strobe` high exactly one cycle, after edge 16; `bit_out`=1, `history`=0001, `bit_count`=1; no further strobes while the button is held.
- Button bounces 1-0-1-0 with 2-cycle pulses, then stays high → exactly one strobe, issued 4 cycles after PRESS_WAIT is last entered.
- Enter bits 1,1,0,0 with clean press/release pairs → strobes on each press; final `history`=1100, `bit_count`=4, `bit_out`=0. Also confirms the 1100 sequence arrives at the downstream detector.
- Release bounces (1-cycle high glitches during RELEASE_WAIT) → no extra strobe.
- Assert reset while in PRESS_WAIT at `cnt`=2 → outputs return to 0 immediately; no strobe after reset is released while the button is still held.
- 256 accepted presses → `bit_count` wraps to 0.
